// File: rtl/rv32_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the core decoder.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_LOAD = 7'b0000011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_CUSTOM = 7'b0001011;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   typedef struct packed {
      logic [2:0]      fmt;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
   } inst_fields_t;

   // True when v is representable as a signed value of the given bit width.
   function automatic logic sext_fits(input logic [XLEN-1:0] v, input int unsigned bits);
      logic [XLEN-1:0] hi;
      hi = XLEN'($signed(v) >>> (bits - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer; immediate range checks only with ENC_RANGE_CHECK_EN.
module inst_pack
   import rv32_pkg::*;
(
   input  inst_fields_t      f,
   output logic [XLEN-1:0]   word,
   output logic              range_ok,
   output logic              fmt_ok
);

   always_comb begin
      word   = '0;
      fmt_ok = 1'b1;
      case (f.fmt)
         FMT_R:   word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
         FMT_I:   word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
         FMT_S:   word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
         FMT_B:   word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                          f.imm[4:1], f.imm[11], f.opcode};
         FMT_U:   word = {f.imm[31:12], f.rd, f.opcode};
         FMT_J:   word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
         default: fmt_ok = 1'b0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   always_comb begin
      range_ok = 1'b1;
      case (f.fmt)
         FMT_I, FMT_S: range_ok = sext_fits(f.imm, 12);
         FMT_B:        range_ok = sext_fits(f.imm, 13) && !f.imm[0];
         FMT_J:        range_ok = sext_fits(f.imm, 21) && !f.imm[0];
         FMT_U:        range_ok = (f.imm[11:0] == 12'h000);
         default:      range_ok = 1'b1;
      endcase
   end
`else
   assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I field bundles and streams them into imem, one word per accept.
// Optional immediate validation: ENC_RANGE_CHECK_EN.
module inst_encoder
   import rv32_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
   parameter int unsigned         DEPTH     = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                fmt,
   input  logic [6:0]                opcode,
   input  logic [2:0]                funct3,
   input  logic [6:0]                funct7,
   input  logic [4:0]                rd,
   input  logic [4:0]                rs1,
   input  logic [4:0]                rs2,
   input  logic [31:0]               imm,
   input  logic                      last,
   output logic                      imem_we,
   output logic [ADDR_W-1:0]         imem_addr,
   output logic [31:0]               imem_wdata,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   inst_fields_t      fields;
   logic [31:0]       word;
   logic              range_ok;
   logic              fmt_ok;
   logic              write_ok;
   logic [CNT_W-1:0]  count_inc;

   assign fields    = '{fmt: fmt, opcode: opcode, funct3: funct3, funct7: funct7,
                        rd: rd, rs1: rs1, rs2: rs2, imm: imm};
   assign write_ok  = fmt_ok & range_ok;
   assign count_inc = count + CNT_W'(1);

   inst_pack u_pack (
      .f        (fields),
      .word     (word),
      .range_ok (range_ok),
      .fmt_ok   (fmt_ok)
   );

   // Control FSM; start wins over any bundle presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         count      <= '0;
         ptr        <= BASE_ADDR;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            ptr      <= BASE_ADDR;
         end else if (state == S_LOAD && in_valid) begin
            if (write_ok) begin
               imem_we    <= 1'b1;
               imem_addr  <= ptr;
               imem_wdata <= word;
               ptr        <= ptr + ADDR_W'(4);
               count      <= count_inc;
            end else begin
               err <= 1'b1;
            end
            // A final bundle ends the program even when it also fills the memory.
            if (last) begin
               state    <= S_DONE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
            end else if (write_ok && count_inc == CNT_W'(DEPTH)) begin
               state    <= S_FULL;
               in_ready <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (DEPTH=4 so the full condition is reachable).
`timescale 1ns/1ps
module tb_inst_encoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n, start, in_valid, last;
   logic             in_ready, imem_we, busy, done, err;
   logic [2:0]       fmt, funct3;
   logic [6:0]       opcode, funct7;
   logic [4:0]       rd, rs1, rs2;
   logic [31:0]      imm, imem_addr, imem_wdata;
   logic [CNT_W-1:0] count;

   int passed = 0;
   int total  = 0;

   inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   // All tasks begin and end 1ns after a rising edge.
   task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [31:0] im, input logic l);
      fmt = f; opcode = op; funct3 = f3; funct7 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
   endtask

   task automatic offer(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im, input logic l,
                        input int budget, output bit acc);
      bit rdy;
      set_fields(f, op, f3, f7, d, s1, s2, im, l);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            acc = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if ({in_ready, imem_we, busy, done, err, count} !== '0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
         $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b err=%b cnt=%0d addr=%h wdata=%h, required all zero",
                  in_ready, imem_we, busy, done, err, count, imem_addr, imem_wdata);
      end else passed++;
      rst_n = 1'b1;
      set_fields(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      total++;
      if ({imem_we, in_ready, busy, count} !== '0) begin
         $display("FAIL idle_ignores_bundle: we=%b rdy=%b busy=%b cnt=%0d, required 0 0 0 0", imem_we, in_ready, busy, count);
      end else passed++;
   endtask

   task automatic test_single();
      bit acc;
      do_start();
      total++;
      if ({in_ready, busy, imem_we} !== 3'b110) begin
         $display("FAIL start_state: rdy/busy/we=%b, required 110", {in_ready, busy, imem_we});
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 2, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h00500093 || count !== 3'd1) begin
         $display("FAIL addi: acc=%b we=%b addr=%h wdata=%h cnt=%0d, required 1 1 00000000 00500093 1",
                  acc, imem_we, imem_addr, imem_wdata, count);
      end else passed++;
      @(posedge clk); #1;
      total++;
      if (imem_we !== 1'b0) begin
         $display("FAIL we_one_cycle: we=%b, required 0", imem_we);
      end else passed++;
   endtask

   task automatic test_back_to_back();
      bit acc;
      do_start();
      offer(rv32_pkg::FMT_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 2, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h002081B3) begin
         $display("FAIL r_add: acc=%b we=%b addr=%h wdata=%h, required 1 1 00000000 002081b3", acc, imem_we, imem_addr, imem_wdata);
      end else passed++;
      offer(rv32_pkg::FMT_S, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h0020A423) begin
         $display("FAIL s_sw: acc=%b we=%b addr=%h wdata=%h, required 1 1 00000004 0020a423", acc, imem_we, imem_addr, imem_wdata);
      end else passed++;
      offer(rv32_pkg::FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h8 || imem_wdata !== 32'hFE208EE3 || count !== 3'd3) begin
         $display("FAIL b_beq: acc=%b we=%b addr=%h wdata=%h cnt=%0d, required 1 1 00000008 fe208ee3 3",
                  acc, imem_we, imem_addr, imem_wdata, count);
      end else passed++;
   endtask

   task automatic test_u_j();
      bit acc;
      do_start();
      offer(rv32_pkg::FMT_U, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 2, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h123452B7) begin
         $display("FAIL u_lui: acc=%b we=%b addr=%h wdata=%h, required 1 1 00000000 123452b7", acc, imem_we, imem_addr, imem_wdata);
      end else passed++;
      offer(rv32_pkg::FMT_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h008000EF) begin
         $display("FAIL j_jal: acc=%b we=%b addr=%h wdata=%h, required 1 1 00000004 008000ef", acc, imem_we, imem_addr, imem_wdata);
      end else passed++;
      total++;
      if ({done, busy, in_ready} !== 3'b100 || count !== 3'd2) begin
         $display("FAIL done_state: done/busy/rdy=%b cnt=%0d, required 100 2", {done, busy, in_ready}, count);
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 2, acc);
      total++;
      if (acc || imem_we !== 1'b0 || done !== 1'b1 || count !== 3'd2) begin
         $display("FAIL done_holds: acc=%b we=%b done=%b cnt=%0d, required 0 0 1 2", acc, imem_we, done, count);
      end else passed++;
   endtask

   task automatic test_full();
      bit acc;
      logic [31:0] exp;
      do_start();
      for (int i = 0; i < 4; i++) begin
         offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0, 2, acc);
         exp = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
         total++;
         if (!acc || imem_we !== 1'b1 || imem_addr !== 32'(4 * i) || imem_wdata !== exp) begin
            $display("FAIL full_write%0d: acc=%b we=%b addr=%h wdata=%h, required 1 1 %h %h",
                     i, acc, imem_we, imem_addr, imem_wdata, 32'(4 * i), exp);
         end else passed++;
      end
      total++;
      if (count !== 3'd4 || {in_ready, busy, done} !== 3'b010) begin
         $display("FAIL full_state: cnt=%0d rdy/busy/done=%b, required 4 010", count, {in_ready, busy, done});
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0, 3, acc);
      total++;
      if (acc || imem_we !== 1'b0 || count !== 3'd4 || done !== 1'b0) begin
         $display("FAIL full_rejects: acc=%b we=%b cnt=%0d done=%b, required 0 0 4 0", acc, imem_we, count, done);
      end else passed++;
      // Filling the memory on the final bundle ends in DONE.
      do_start();
      for (int i = 0; i < 4; i++) begin
         offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'(i == 3), 2, acc);
      end
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'hC || {done, busy, in_ready} !== 3'b100 || count !== 3'd4) begin
         $display("FAIL last_at_depth: acc=%b we=%b addr=%h done/busy/rdy=%b cnt=%0d, required 1 1 0000000c 100 4",
                  acc, imem_we, imem_addr, {done, busy, in_ready}, count);
      end else passed++;
   endtask

   task automatic test_illegal_fmt();
      bit acc;
      do_start();
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 2, acc);
      offer(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b0 || err !== 1'b1 || count !== 3'd1) begin
         $display("FAIL illegal_fmt: acc=%b we=%b err=%b cnt=%0d, required 1 0 1 1", acc, imem_we, err, count);
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h00700113 || err !== 1'b1) begin
         $display("FAIL after_illegal: acc=%b we=%b addr=%h wdata=%h err=%b, required 1 1 00000004 00700113 1",
                  acc, imem_we, imem_addr, imem_wdata, err);
      end else passed++;
      offer(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b0 || done !== 1'b1 || count !== 3'd2) begin
         $display("FAIL illegal_last: acc=%b we=%b done=%b cnt=%0d, required 1 0 1 2", acc, imem_we, done, count);
      end else passed++;
   endtask

   task automatic test_range();
      bit acc;
      do_start();
      total++;
      if ({err, done, count} !== '0) begin
         $display("FAIL start_clears: err=%b done=%b cnt=%0d, required 0 0 0", err, done, count);
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 2, acc);
`ifdef ENC_RANGE_CHECK_EN
      total++;
      if (!acc || imem_we !== 1'b0 || err !== 1'b1 || count !== 3'd0) begin
         $display("FAIL imm_range: acc=%b we=%b err=%b cnt=%0d, required 1 0 1 0", acc, imem_we, err, count);
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h00500093) begin
         $display("FAIL after_range: acc=%b we=%b addr=%h wdata=%h, required 1 1 00000000 00500093", acc, imem_we, imem_addr, imem_wdata);
      end else passed++;
`else
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h80000093 || err !== 1'b0) begin
         $display("FAIL imm_truncate: acc=%b we=%b addr=%h wdata=%h err=%b, required 1 1 00000000 80000093 0",
                  acc, imem_we, imem_addr, imem_wdata, err);
      end else passed++;
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1, acc);
      total++;
      if (!acc || imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h00500093) begin
         $display("FAIL after_truncate: acc=%b we=%b addr=%h wdata=%h, required 1 1 00000004 00500093", acc, imem_we, imem_addr, imem_wdata);
      end else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      bit acc;
      do_start();
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 2, acc);
      set_fields(rv32_pkg::FMT_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      in_valid = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({in_ready, imem_we, busy, done, err, count} !== '0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
         $display("FAIL mid_reset: rdy=%b we=%b busy=%b done=%b err=%b cnt=%0d addr=%h wdata=%h, required all zero",
                  in_ready, imem_we, busy, done, err, count, imem_addr, imem_wdata);
      end else passed++;
      in_valid = 1'b0;
      rst_n = 1'b1;
      do_start();
      offer(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 2, acc);
      offer(rv32_pkg::FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1, acc);
      // Restart while a bundle is held valid: the start cycle must not consume it.
      set_fields(rv32_pkg::FMT_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      in_valid = 1'b1;
      do_start();
      total++;
      if (imem_we !== 1'b0 || err !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
         $display("FAIL start_priority: we=%b err=%b cnt=%0d rdy=%b, required 0 0 0 1", imem_we, err, count, in_ready);
      end else passed++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h002081B3 || count !== 3'd1) begin
         $display("FAIL held_after_start: we=%b addr=%h wdata=%h cnt=%0d, required 1 00000000 002081b3 1",
                  imem_we, imem_addr, imem_wdata, count);
      end else passed++;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_u_j();
      test_full();
      test_illegal_fmt();
      test_range();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
